// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Collects rising edges on N_SRC interrupt lines into a pending register,
// arbitrates the enabled pending sources by fixed priority (index 0 highest)
// and runs a single request/acknowledge/end-of-interrupt handshake with the
// core. A request that is not acknowledged within ACK_TIMEOUT cycles is
// withdrawn and its pending bit re-queued.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   reset      : asynchronous active-low reset
//   irq_src    : per-source interrupt lines (rising-edge sensitive)
//   mask_wr    : write strobe for the mask register
//   mask_data  : new mask value (1 = source enabled)
//   ack        : core acknowledge of the current request (honoured in REQ)
//   eoi        : core end-of-interrupt strobe (honoured in SERVICE)
//   interrupt  : registered request to the core
//   irq_id     : registered index of the source requested / in service
//   pending    : current pending register
//   mask       : current mask register
//   busy       : high while a request is in REQ or SERVICE
// -----------------------------------------------------------------------------
module interrupt_controller #(
    parameter int N_SRC       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_wr,
    input  logic [N_SRC-1:0] mask_data,
    input  logic             ack,
    input  logic             eoi,
    output logic             interrupt,
    output logic [3:0]       irq_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] src_q, src_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic             interrupt_q, interrupt_d;
    logic [3:0]       irq_id_q, irq_id_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [N_SRC-1:0] src_edge;
    logic [N_SRC-1:0] req_v;
    logic [N_SRC-1:0] grant;
    logic [3:0]       grant_idx;
    logic [N_SRC-1:0] id_onehot;

    assign src_edge = irq_src & ~src_q;
    assign req_v    = pending_q & mask_q;

    // Fixed-priority pick: scanning from the top down lets the lowest set
    // index overwrite earlier hits, so it ends up as the winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_v[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = 4'(i);
            end
        end
    end

    // One-hot form of the in-flight id, used to re-queue on timeout without
    // indexing the vector by a wider-than-needed id.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_onehot[i] = (irq_id_q == 4'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        interrupt_d = interrupt_q;
        irq_id_d    = irq_id_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        src_d       = irq_src;
        mask_d      = mask_wr ? mask_data : mask_q;

        case (state_q)
            IDLE: begin
                if (|req_v) begin
                    state_d     = REQ;
                    irq_id_d    = grant_idx;
                    pending_d   = pending_q & ~grant;
                    interrupt_d = 1'b1;
                    cnt_d       = 8'(ACK_TIMEOUT);
                end
            end
            REQ: begin
                cnt_d = cnt_q - 8'd1;
                if (ack) begin
                    // ack wins over a timeout expiring in the same cycle
                    state_d     = SERVICE;
                    interrupt_d = 1'b0;
                end else if (cnt_d == 8'd0) begin
                    state_d     = IDLE;
                    interrupt_d = 1'b0;
                    pending_d   = pending_q | id_onehot;
                end
            end
            SERVICE: begin
                interrupt_d = 1'b0;
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                interrupt_d = 1'b0;
            end
        endcase

        // New edges are applied last so a set always beats a same-cycle clear.
        pending_d = pending_d | src_edge;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            interrupt_q <= 1'b0;
            irq_id_q    <= '0;
            pending_q   <= '0;
            mask_q      <= '1;
            src_q       <= '1;  // lines already high at release give no edge
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            interrupt_q <= interrupt_d;
            irq_id_q    <= irq_id_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
        end
    end

    assign interrupt = interrupt_q;
    assign irq_id    = irq_id_q;
    assign pending   = pending_q;
    assign mask      = mask_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed bench for interrupt_controller with default parameters
// (N_SRC = 8, ACK_TIMEOUT = 16). Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, so every observation sees
// the registers updated by the edge just passed.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic       clk;
    logic       reset;
    logic [7:0] irq_src;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic       ack;
    logic       eoi;
    logic       interrupt;
    logic [3:0] irq_id;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       busy;

    int checks;
    int failures;

    interrupt_controller #(
        .N_SRC       (8),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .ack       (ack),
        .eoi       (eoi),
        .interrupt (interrupt),
        .irq_id    (irq_id),
        .pending   (pending),
        .mask      (mask),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // interrupt, busy, irq_id, pending in one call
    task automatic chk_all(input string tag, input logic i_exp, input logic b_exp,
                           input logic [3:0] id_exp, input logic [7:0] p_exp);
        chk({tag, ".interrupt"}, 32'(interrupt), 32'(i_exp));
        chk({tag, ".busy"},      32'(busy),      32'(b_exp));
        chk({tag, ".irq_id"},    32'(irq_id),    32'(id_exp));
        chk({tag, ".pending"},   32'(pending),   32'(p_exp));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        irq_src   = 8'h00;
        mask_wr   = 1'b0;
        mask_data = 8'h00;
        ack       = 1'b0;
        eoi       = 1'b0;

        // Reset state
        tick();
        tick();
        chk_all("rst", 1'b0, 1'b0, 4'd0, 8'h00);
        chk("rst.mask", 32'(mask), 32'hFF);
        reset = 1'b1;
        tick();
        tick();
        chk_all("post_rst", 1'b0, 1'b0, 4'd0, 8'h00);

        // ack pulsed in IDLE with nothing pending is ignored
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("ack_idle", 1'b0, 1'b0, 4'd0, 8'h00);

        // Single source 3: pending on edge N, interrupt on edge N+1
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        chk_all("s3_pend", 1'b0, 1'b0, 4'd0, 8'h08);
        tick();
        chk_all("s3_req", 1'b1, 1'b1, 4'd3, 8'h00);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("s3_svc", 1'b0, 1'b1, 4'd3, 8'h00);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk_all("s3_eoi", 1'b0, 1'b0, 4'd3, 8'h00);

        // Sources 2 and 5 together: 2 first, 5 right after the eoi
        irq_src = 8'h24;
        tick();
        irq_src = 8'h00;
        chk("dual_pend", 32'(pending), 32'h24);
        tick();
        chk_all("dual_req2", 1'b1, 1'b1, 4'd2, 8'h20);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk_all("dual_idle", 1'b0, 1'b0, 4'd2, 8'h20);
        tick();
        chk_all("dual_req5", 1'b1, 1'b1, 4'd5, 8'h00);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("dual_done.busy", 32'(busy), 32'h0);

        // Masked source 0 stays pending until the mask is reopened
        mask_wr   = 1'b1;
        mask_data = 8'hFE;
        tick();
        mask_wr = 1'b0;
        chk("mask_fe", 32'(mask), 32'hFE);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        chk_all("masked", 1'b0, 1'b0, 4'd5, 8'h01);
        mask_wr   = 1'b1;
        mask_data = 8'hFF;
        tick();
        mask_wr = 1'b0;
        chk("mask_ff", 32'(mask), 32'hFF);
        chk("mask_ff.interrupt", 32'(interrupt), 32'h0);
        tick();
        chk_all("unmask_req", 1'b1, 1'b1, 4'd0, 8'h00);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;

        // Timeout on source 1; an eoi pulse in REQ must not disturb the count
        irq_src = 8'h02;
        tick();
        irq_src = 8'h00;
        tick();                                  // edge E: enter REQ
        chk_all("to_req", 1'b1, 1'b1, 4'd1, 8'h00);
        eoi = 1'b1;
        tick();                                  // E+1
        eoi = 1'b0;
        chk_all("eoi_in_req", 1'b1, 1'b1, 4'd1, 8'h00);
        for (int k = 0; k < 14; k++) tick();     // E+15
        chk_all("to_last", 1'b1, 1'b1, 4'd1, 8'h00);
        tick();                                  // E+16: abandoned, re-queued
        chk_all("to_drop", 1'b0, 1'b0, 4'd1, 8'h02);
        tick();                                  // E+17: re-request
        chk_all("to_rereq", 1'b1, 1'b1, 4'd1, 8'h00);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;

        // Set beats clear when source 2 re-edges on its own grant edge;
        // source 2 arriving during SERVICE of source 0 does not preempt
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        chk_all("sw_req0", 1'b1, 1'b1, 4'd0, 8'h00);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        tick();
        chk_all("sw_nopreempt", 1'b0, 1'b1, 4'd0, 8'h04);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        chk_all("sw_grant2", 1'b1, 1'b1, 4'd2, 8'h04);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        chk_all("sw_regrant2", 1'b1, 1'b1, 4'd2, 8'h00);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;

        // Asynchronous reset in SERVICE with source 7 pending
        irq_src = 8'h81;
        tick();
        tick();
        chk_all("ar_req", 1'b1, 1'b1, 4'd0, 8'h80);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        mask_wr   = 1'b1;
        mask_data = 8'h7F;
        tick();
        mask_wr = 1'b0;
        chk_all("ar_svc", 1'b0, 1'b1, 4'd0, 8'h80);
        chk("ar_svc.mask", 32'(mask), 32'h7F);
        #2;
        reset = 1'b0;
        #1;
        chk_all("ar_async", 1'b0, 1'b0, 4'd0, 8'h00);
        chk("ar_async.mask", 32'(mask), 32'hFF);
        tick();
        reset = 1'b1;
        tick();
        tick();
        // irq_src[7] and [0] still high: no edge after release, no re-queue
        chk_all("ar_release", 1'b0, 1'b0, 4'd0, 8'h00);
        irq_src = 8'h00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
